// File: rtl/nsa_pkg.sv
// Shared types and sizing helpers for the nibble-serial adder.
package nsa_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } nsa_state_e;

  typedef struct packed {
    logic [15:0] n;
    logic [15:0] idx_w;
  } nsa_geom_t;

  // Nibble count and index-counter width for a given operand width.
  function automatic nsa_geom_t nsa_geom(input int width);
    nsa_geom_t g;
    int        n;
    n       = width / NIBBLE_W;
    g.n     = 16'(n);
    g.idx_w = 16'((n > 1) ? $clog2(n) : 1);
    return g;
  endfunction

endpackage

// File: rtl/carry_select_adder.sv
// Existing 4-bit carry-select adder: low pair ripples, high pair is
// precomputed for both carry-ins and selected by the low-pair carry.
module carry_select_adder (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       cin,
  output logic [3:0] S,
  output logic       cout
);

  logic [2:0] lo;
  logic [2:0] hi0;
  logic [2:0] hi1;

  always_comb begin
    lo   = {1'b0, A[1:0]} + {1'b0, B[1:0]} + {2'b00, cin};
    hi0  = {1'b0, A[3:2]} + {1'b0, B[3:2]};
    hi1  = {1'b0, A[3:2]} + {1'b0, B[3:2]} + 3'd1;
    S    = {(lo[2] ? hi1[1:0] : hi0[1:0]), lo[1:0]};
    cout = lo[2] ? hi1[2] : hi0[2];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder streamed one nibble per cycle through a single 4-bit adder.
// Optional signed-overflow output enabled by defining NSA_OVF_EN.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             cout,
`ifdef NSA_OVF_EN
  output logic             ovf,
`endif
  output nsa_state_e       state_dbg
);

  localparam nsa_geom_t GEOM  = nsa_geom(WIDTH);
  localparam int        N     = int'(GEOM.n);
  localparam int        IDX_W = int'(GEOM.idx_w);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  // Handshakes: a transfer happens on a rising edge where valid && ready;
  // valid never depends on ready, and the offered data stays stable until
  // the transfer.
  nsa_state_e state, state_nxt;

  logic [WIDTH-1:0]    a_reg, b_reg, s_reg;
  logic                carry_reg;
  logic [IDX_W-1:0]    idx;
  logic [NIBBLE_W-1:0] a_nib, b_nib, nib_sum;
  logic                nib_cout;
  logic                accept;
  logic                last_nib;

  assign accept   = in_valid && in_ready;
  assign last_nib = (state == RUN) && (idx == LAST_IDX);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    state_dbg = state;
  end

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int k = 0; k < N; k++) begin
      if (idx == IDX_W'(k)) begin
        a_nib = a_reg[k*NIBBLE_W +: NIBBLE_W];
        b_nib = b_reg[k*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  carry_select_adder u_csa (
    .A    (a_nib),
    .B    (b_nib),
    .cin  (carry_reg),
    .S    (nib_sum),
    .cout (nib_cout)
  );

  // Datapath: idx parks at the last nibble and is re-zeroed on the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      carry_reg <= 1'b0;
      idx       <= '0;
    end else if (accept) begin
      a_reg     <= A;
      b_reg     <= B;
      s_reg     <= '0;
      carry_reg <= cin;
      idx       <= '0;
    end else if (state == RUN) begin
      for (int k = 0; k < N; k++) begin
        if (idx == IDX_W'(k)) s_reg[k*NIBBLE_W +: NIBBLE_W] <= nib_sum;
      end
      carry_reg <= nib_cout;
      if (idx != LAST_IDX) idx <= idx + 1'b1;
    end
  end

  assign S    = s_reg;
  assign cout = carry_reg;

`ifdef NSA_OVF_EN
  logic ovf_reg;

  // Operands share a sign but the top result nibble's sign bit differs.
  always_ff @(posedge clk) begin
    if (rst || accept) ovf_reg <= 1'b0;
    else if (last_nib)
      ovf_reg <= (a_reg[WIDTH-1] == b_reg[WIDTH-1]) &&
                 (nib_sum[NIBBLE_W-1] != a_reg[WIDTH-1]);
  end

  assign ovf = ovf_reg;
`else
  logic unused_last;
  assign unused_last = last_nib;
`endif

endmodule
